// File: rtl/pix_deinterleave2.sv
// Serial-to-pair pixel unpacker: one pixel per beat in, even/odd pixel pair out.
// Regenerates the end-of-line marker, pads odd-length lines and resyncs on a stray start-of-line.
module pix_deinterleave2 #(
  parameter int DW     = 8,
  parameter int LINE_W = 640
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_sol,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data0,
  output logic [DW-1:0] m_data1,
  output logic          m_last,
  output logic          m_pad,
  output logic          err_sync
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_EVEN  = 2'd1;
  localparam logic [1:0]  ST_ODD   = 2'd2;
  localparam logic [11:0] LAST_COL = 12'(LINE_W - 1);

  logic [1:0]    state_q, state_d;
  logic [11:0]   col_q, col_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          mv_q, mv_d;
  logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
  logic          last_q, last_d, pad_q, pad_d, err_q, err_d;
  logic          at_last, completing, accept;

  always_comb begin
    at_last    = (col_q == LAST_COL);
    // Only beats that finish a pair need room in the output register.
    completing = (state_q == ST_ODD) || ((state_q == ST_EVEN) && at_last);
    s_ready    = completing ? (!mv_q || m_ready) : 1'b1;
    accept     = s_valid && s_ready;

    state_d = state_q;
    col_d   = col_q;
    hold_d  = hold_q;
    mv_d    = mv_q && !m_ready;
    d0_d    = d0_q;
    d1_d    = d1_q;
    last_d  = last_q;
    pad_d   = pad_q;
    err_d   = 1'b0;

    if (state_q == 2'd3) state_d = ST_IDLE;

    if (accept) begin
      if (s_sol) begin
        // Start of line always wins: any partial pair is dropped.
        err_d   = (state_q != ST_IDLE);
        hold_d  = s_data;
        col_d   = 12'd1;
        state_d = ST_ODD;
      end else begin
        case (state_q)
          ST_EVEN: begin
            if (at_last) begin
              mv_d    = 1'b1;
              d0_d    = s_data;
              d1_d    = '0;
              last_d  = 1'b1;
              pad_d   = 1'b1;
              col_d   = 12'd0;
              state_d = ST_IDLE;
            end else begin
              hold_d  = s_data;
              col_d   = col_q + 12'd1;
              state_d = ST_ODD;
            end
          end
          ST_ODD: begin
            mv_d    = 1'b1;
            d0_d    = hold_q;
            d1_d    = s_data;
            last_d  = at_last;
            pad_d   = 1'b0;
            col_d   = at_last ? 12'd0 : col_q + 12'd1;
            state_d = at_last ? ST_IDLE : ST_EVEN;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      hold_q  <= '0;
      mv_q    <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      hold_q  <= hold_d;
      mv_q    <= mv_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
      err_q   <= err_d;
    end
  end

  assign m_valid  = mv_q;
  assign m_data0  = d0_q;
  assign m_data1  = d1_q;
  assign m_last   = last_q;
  assign m_pad    = pad_q;
  assign err_sync = err_q;

endmodule

// File: tb/tb_pix_deinterleave2.sv
// Scoreboard bench for pix_deinterleave2: instance 0 uses 4-pixel lines, instance 1 uses 5-pixel lines.
module tb_pix_deinterleave2;

  typedef struct packed {
    logic       last;
    logic       pad;
    logic [7:0] d0;
    logic [7:0] d1;
  } pair_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid [2];
  logic       s_ready [2];
  logic [7:0] s_data  [2];
  logic       s_sol   [2];
  logic       m_valid [2];
  logic       m_ready [2];
  logic [7:0] m_data0 [2];
  logic [7:0] m_data1 [2];
  logic       m_last  [2];
  logic       m_pad   [2];
  logic       err_sync[2];

  pair_t exp_q0[$];
  pair_t exp_q1[$];
  int    total = 0;
  int    bad   = 0;
  int    err_cnt[2];

  always #5 clk = ~clk;

  pix_deinterleave2 #(.DW(8), .LINE_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_sol(s_sol[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data0(m_data0[0]), .m_data1(m_data1[0]),
    .m_last(m_last[0]), .m_pad(m_pad[0]), .err_sync(err_sync[0])
  );

  pix_deinterleave2 #(.DW(8), .LINE_W(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_sol(s_sol[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data0(m_data0[1]), .m_data1(m_data1[1]),
    .m_last(m_last[1]), .m_pad(m_pad[1]), .err_sync(err_sync[1])
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] a, input logic [7:0] b,
                      input logic l, input logic p);
    pair_t e;
    e = {l, p, a, b};
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a beat until accepted; n returns the number of cycles it took.
  task automatic beat(input int i, input logic [7:0] d, input logic sol, output int n);
    logic ok;
    s_valid[i] = 1'b1;
    s_data[i]  = d;
    s_sol[i]   = sol;
    n = 0;
    do begin
      @(negedge clk);
      ok = s_ready[i];
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 40);
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    s_valid[i] = 1'b0;
    s_sol[i]   = 1'b0;
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk(tag, {27'd0, m_valid[i], m_last[i], m_pad[i], err_sync[i], s_ready[i]}, 32'h1);
    chk(tag, {16'd0, m_data0[i], m_data1[i]}, 32'd0);
  endtask

  always @(negedge clk) begin
    pair_t got;
    pair_t want;
    for (int i = 0; i < 2; i++) begin
      if (err_sync[i]) err_cnt[i]++;
      if (rst_n && m_valid[i] && m_ready[i]) begin
        got = {m_last[i], m_pad[i], m_data0[i], m_data1[i]};
        if ((i == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
          chk("unexpected_pair", 32'(got), 32'hFFFF_FFFF);
        end else begin
          want = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk((i == 0) ? "pair_w4" : "pair_w5", 32'(got), 32'(want));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    err_cnt[0] = 0;
    err_cnt[1] = 0;
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0;
      s_data[i]  = 8'h00;
      s_sol[i]   = 1'b0;
      m_ready[i] = 1'b1;
    end
    rst_n = 1'b0;
    idle(3);
    chk_zero(0, "reset_w4");
    chk_zero(1, "reset_w5");
    rst_n = 1'b1;
    idle(2);

    // Basic 4-pixel line, latency of the first pair
    push(0, 8'h10, 8'h11, 1'b0, 1'b0);
    push(0, 8'h12, 8'h13, 1'b1, 1'b0);
    beat(0, 8'h10, 1'b1, n);
    chk("t1_mv_before", 32'(m_valid[0]), 32'd0);
    beat(0, 8'h11, 1'b0, n);
    chk("t1_mv_latency", 32'(m_valid[0]), 32'd1);
    beat(0, 8'h12, 1'b0, n);
    beat(0, 8'h13, 1'b0, n);
    idle(3);
    chk("t1_q_empty", 32'(exp_q0.size()), 32'd0);

    // Backpressure: only the pair-completing beat stalls
    push(0, 8'h40, 8'h41, 1'b0, 1'b0);
    push(0, 8'h42, 8'h43, 1'b1, 1'b0);
    beat(0, 8'h40, 1'b1, n);
    beat(0, 8'h41, 1'b0, n);
    m_ready[0] = 1'b0;
    beat(0, 8'h42, 1'b0, n);
    chk("t2_even_no_stall", 32'(n), 32'd1);
    s_valid[0] = 1'b1;
    s_data[0]  = 8'h43;
    repeat (4) begin
      @(negedge clk);
      chk("t2_s_ready_low", 32'(s_ready[0]), 32'd0);
      chk("t2_hold", {15'd0, m_valid[0], m_data0[0], m_data1[0]}, 32'h1_4041);
      @(posedge clk);
      #1;
    end
    m_ready[0] = 1'b1;
    beat(0, 8'h43, 1'b0, n);
    idle(3);
    chk("t2_q_empty", 32'(exp_q0.size()), 32'd0);

    // Odd-length line is padded on its final pair
    push(1, 8'hA0, 8'hA1, 1'b0, 1'b0);
    push(1, 8'hA2, 8'hA3, 1'b0, 1'b0);
    push(1, 8'hA4, 8'h00, 1'b1, 1'b1);
    beat(1, 8'hA0, 1'b1, n);
    for (int k = 1; k < 5; k++) beat(1, 8'(8'hA0 + k), 1'b0, n);
    idle(3);
    chk("t3_q_empty", 32'(exp_q1.size()), 32'd0);
    chk("t3_no_err", 32'(err_cnt[1]), 32'd0);

    // Resync mid-pair: partial pixel 0x03 is dropped
    push(0, 8'h01, 8'h02, 1'b0, 1'b0);
    push(0, 8'h20, 8'h21, 1'b0, 1'b0);
    push(0, 8'h22, 8'h23, 1'b1, 1'b0);
    beat(0, 8'h01, 1'b1, n);
    beat(0, 8'h02, 1'b0, n);
    beat(0, 8'h03, 1'b0, n);
    beat(0, 8'h20, 1'b1, n);
    beat(0, 8'h21, 1'b0, n);
    beat(0, 8'h22, 1'b0, n);
    beat(0, 8'h23, 1'b0, n);
    idle(3);
    chk("t4_err_once", 32'(err_cnt[0]), 32'd1);
    chk("t4_q_empty", 32'(exp_q0.size()), 32'd0);

    // Resync on a pair-completing beat: no pair for the old line
    push(0, 8'h50, 8'h51, 1'b0, 1'b0);
    push(0, 8'h53, 8'h54, 1'b0, 1'b0);
    push(0, 8'h55, 8'h56, 1'b1, 1'b0);
    beat(0, 8'h50, 1'b1, n);
    beat(0, 8'h51, 1'b0, n);
    beat(0, 8'h52, 1'b0, n);
    beat(0, 8'h53, 1'b1, n);
    beat(0, 8'h54, 1'b0, n);
    beat(0, 8'h55, 1'b0, n);
    beat(0, 8'h56, 1'b0, n);
    idle(3);
    chk("t4b_err", 32'(err_cnt[0]), 32'd2);
    chk("t4b_q_empty", 32'(exp_q0.size()), 32'd0);

    // Beats without start-of-line in IDLE are dropped silently
    for (int k = 0; k < 3; k++) begin
      beat(0, 8'(8'h77 + k), 1'b0, n);
      chk("t5_idle_ready", 32'(n), 32'd1);
    end
    push(0, 8'h60, 8'h61, 1'b0, 1'b0);
    push(0, 8'h62, 8'h63, 1'b1, 1'b0);
    beat(0, 8'h60, 1'b1, n);
    for (int k = 1; k < 4; k++) beat(0, 8'(8'h60 + k), 1'b0, n);
    idle(3);
    chk("t5_no_err", 32'(err_cnt[0]), 32'd2);
    chk("t5_q_empty", 32'(exp_q0.size()), 32'd0);

    // Reset mid-line with a pair held in the output register
    m_ready[0] = 1'b0;
    beat(0, 8'h30, 1'b1, n);
    beat(0, 8'h31, 1'b0, n);
    beat(0, 8'h32, 1'b0, n);
    chk("t6_mv_before_rst", 32'(m_valid[0]), 32'd1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk_zero(0, "t6_reset_w4");
    chk_zero(1, "t6_reset_w5");
    m_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) beat(0, 8'(8'h33 + k), 1'b0, n);
    idle(2);
    chk("t6_no_out", 32'(m_valid[0]), 32'd0);
    push(0, 8'h80, 8'h81, 1'b0, 1'b0);
    push(0, 8'h82, 8'h83, 1'b1, 1'b0);
    beat(0, 8'h80, 1'b1, n);
    for (int k = 1; k < 4; k++) beat(0, 8'(8'h80 + k), 1'b0, n);
    idle(4);
    chk("t6_q_empty", 32'(exp_q0.size()), 32'd0);
    chk("t6_err_total", 32'(err_cnt[0]), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pix_deinterleave2.md
Name: pix_deinterleave2

Overview:
- Converts a serial pixel stream, one pixel per beat, back into parallel even/odd pixel pairs, two pixels per beat.
- It is the receive/unpack counterpart of the two-input alternating selector used on the output side.
- It sits between the line-scan pixel source and the dual-lane filter datapath.
- Line framing comes from a start-of-line marker; the block regenerates the last-pair marker and pads odd-length lines.

Parameters:
DW, 8, pixel width in bits
LINE_W, 640, pixels per line; legal range 2..4095; may be odd

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
s_valid  input  1  input pixel valid
s_ready  output  1  input pixel accepted when s_valid && s_ready
s_data  input  DW  input pixel
s_sol  input  1  start of line; qualifies the current beat as column 0
m_valid  output  1  output pair valid
m_ready  input  1  downstream ready; pair consumed when m_valid && m_ready
m_data0  output  DW  even-column pixel
m_data1  output  DW  odd-column pixel; 0 when m_pad=1
m_last  output  1  pair contains the final pixel of the line
m_pad  output  1  m_data1 is padding (odd LINE_W, final pair only)
err_sync  output  1  one-cycle pulse: s_sol arrived on a beat other than column 0

Behaviour:
- Reset: sampled on the clk edge while rst_n=0.
  - m_valid=0, m_data0=0, m_data1=0, m_last=0, m_pad=0, err_sync=0.
  - State IDLE, column counter col=0, hold register=0.
  - Any in-flight pair or partial pair is discarded.
  - Reset applied mid-line behaves identically.
- Column counter: 12 bits. It increments on every accepted in-line beat, clears to 0 after the last pixel (col==LINE_W-1), and never exceeds LINE_W-1.
- State machine:
  - IDLE: waiting for a line.
    - s_ready=1.
    - An accepted beat with s_sol=0 is dropped silently, with no error.
    - An accepted beat with s_sol=1 latches s_data into the hold register, sets col=1 and moves to ODD.
    - Special case: if LINE_W were 1 the pixel would be emitted as a pad pair, but LINE_W>=2 makes this unreachable.
  - EVEN: expecting an even column, col even and nonzero.
    - An accepted beat latches into the hold register and goes to ODD.
    - Exception: if col==LINE_W-1 (odd LINE_W), emit pair {hold=s_data, data1=0, m_last=1, m_pad=1} and go to IDLE.
  - ODD: expecting an odd column.
    - An accepted beat emits pair {m_data0=hold, m_data1=s_data}.
    - m_last=1 and next state IDLE if col==LINE_W-1; otherwise next state EVEN.
- Output register: single stage.
  - A pair loads on the edge after the completing beat is accepted, giving 1-cycle latency.
  - m_valid holds, with data stable, until m_ready.
  - Simultaneous drain and load in the same cycle is allowed and required, giving full throughput of one pair per 2 input beats with no bubbles.
- s_ready rule:
  - In IDLE, and in EVEN when not the final column: s_ready=1.
  - In beats that complete a pair (ODD, or the final EVEN of an odd line): s_ready = !m_valid || m_ready.
  - s_ready is combinational from state/col/m_valid/m_ready only. It does not depend on s_valid.
- Resync:
  - An accepted beat with s_sol=1 while state is EVEN or ODD pulses err_sync the next cycle.
  - Any partial pair in the hold register is discarded.
  - The beat is treated as column 0 of a new line: hold=s_data, col=1, state ODD.
  - An already-emitted pair in the output register is unaffected.
  - s_sol on a beat that completes a pair also counts as a resync: no pair is emitted for the old line.
- s_sol=1 in IDLE is normal line start and does not raise err_sync.
- m_data1 is 0 whenever m_pad=1. m_last and m_pad are valid only with m_valid.

Test Plan:
1. LINE_W=4, continuous s_valid, m_ready=1, pixels 0x10..0x13 with s_sol on 0x10 -> pairs (0x10,0x11,last=0) then (0x12,0x13,last=1); first m_valid the cycle after the 0x11 beat; state returns to IDLE.
2. LINE_W=4, m_ready=0 for 5 cycles after the first pair -> s_ready drops only on the 0x13 beat; pair (0x10,0x11) held stable; releasing m_ready gives both pairs in order with no loss or duplication.
3. LINE_W=5, pixels 0xA0..0xA4 -> (0xA0,0xA1), (0xA2,0xA3), (0xA4,0x00, last=1, pad=1).
4. LINE_W=4, beats 0x01(sol), 0x02, 0x03, then 0x20 with s_sol=1 -> err_sync pulses once; 0x03 is discarded; next pairs are (0x20,next) for the new line.
5. Three beats with s_sol=0 in IDLE, then a normal line -> leading beats are dropped, s_ready=1 throughout, no err_sync, and line pairs are correct.
6. rst_n=0 for one cycle while m_valid=1 mid-line -> next cycle m_valid=0, all outputs 0; a subsequent line without s_sol is ignored until s_sol is seen.
